wb_sram_arbiter: RTL and testbench
==================================

Name: wb_sram_arbiter

Overview:
- Two-master, one-slave Wishbone arbiter that shares the 32-bit SRAM controller between the ARM2 core (m0) and the host/tube DMA port (m1).
- Grants are round-robin and held for a whole Wishbone cycle (cyc), so a granted master can issue back-to-back strobes without re-arbitration.
- A per-access watchdog terminates accesses the slave never acknowledges and reports them with an error pulse.
- The block sits directly in front of the SRAM controller's Wishbone port.

Parameters:
- timeout, 255: cycles a granted strobe may wait for s_ack_i before the watchdog fires; 0 disables the watchdog.
- cnt_width, 8: width of the watchdog counter; must hold timeout.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- m0_cyc_i  input  1  master 0 bus cycle
- m0_stb_i  input  1  master 0 strobe
- m0_we_i  input  1  master 0 write enable
- m0_adr_i  input  32  master 0 byte address
- m0_sel_i  input  4  master 0 byte select
- m0_dat_i  input  32  master 0 write data
- m0_dat_o  output  32  read data to master 0
- m0_ack_o  output  1  master 0 acknowledge
- m0_err_o  output  1  master 0 watchdog error
- m1_* (cyc_i, stb_i, we_i, adr_i, sel_i, dat_i, dat_o, ack_o, err_o): identical set for master 1
- s_cyc_o  output  1  slave cycle
- s_stb_o  output  1  slave strobe
- s_we_o  output  1  slave write enable
- s_adr_o  output  32  slave address
- s_sel_o  output  4  slave byte select
- s_dat_o  output  32  slave write data
- s_dat_i  input  32  slave read data
- s_ack_i  input  1  slave acknowledge
- gnt_o  output  2  one-hot current grant (bit0 = m0, bit1 = m1); 00 = idle

Behaviour:
- Reset (synchronous): state IDLE, gnt_o = 00, priority pointer favours m0, watchdog counter 0, abort flag 0.
  - Consequently s_cyc_o, s_stb_o, s_we_o, m*_ack_o and m*_err_o are all 0.
  - s_adr_o, s_sel_o and s_dat_o are 0 while idle.
- States: IDLE, GNT0, GNT1; grant is registered.
- IDLE:
  - Only m0_cyc_i set → GNT0. Only m1_cyc_i set → GNT1.
  - Both set → grant the master favoured by the pointer.
  - Arbitration latency is one cycle: the request is sampled in cycle N and the slave sees the strobe from cycle N+1.
- GNTx:
  - s_cyc_o = mx_cyc_i & ~abort; s_stb_o = mx_stb_i & mx_cyc_i & ~abort.
  - s_we_o, s_adr_o, s_sel_o and s_dat_o are muxed combinationally from master x.
  - mx_ack_o = s_ack_i; the other master's ack and err are 0.
  - Both m0_dat_o and m1_dat_o = s_dat_i (no gating needed; qualified by ack).
- Release: when mx_cyc_i is low in GNTx, the pointer is set to favour the other master and the arbiter re-arbitrates in the same cycle:
  - other master's cyc set → GNTy directly;
  - otherwise → IDLE.
  - Both masters requesting continuously therefore alternate grants on each cyc drop.
- Grant never changes while the granted master holds cyc high, regardless of the other requester.
- Watchdog (timeout != 0):
  - Counter increments each cycle s_stb_o = 1 and s_ack_i = 0; it clears on s_ack_i and on grant change.
  - When the count reaches timeout: mx_err_o pulses for one cycle, the counter clears, and abort is set.
  - abort forces s_cyc_o and s_stb_o low and clears when mx_cyc_i drops; release then proceeds normally.
  - A s_ack_i arriving in the same cycle as the timeout wins: ack is delivered, no err.
- s_ack_i while in IDLE or while abort is set is ignored (not forwarded to any master).
- Reset mid-cycle: the grant is dropped immediately and slave strobes return to 0 on the next edge; masters must restart.

Test Plan:
- m0 single read at 0x0000_0100, slave acks after 2 cycles → gnt_o = 01 one cycle after cyc; s_adr_o = 0x100; m0_ack_o coincides with s_ack_i; m1_ack_o stays 0.
- m0 and m1 assert cyc in the same cycle from reset → m0 granted first; on m0 cyc drop, gnt_o goes 01 → 10 in the same cycle with no IDLE gap; m1 write data appears on s_dat_o.
- Both masters hold requests across 4 back-to-back cycles → grants alternate m0, m1, m0, m1; m1 never waits more than one m0 cycle.
- m0 issues 3 strobes within one cyc while m1 requests → grant stays 01 until all 3 acks complete and cyc drops.
- timeout = 4, slave never acks m1 → m1_err_o pulses exactly 4 cycles after stb; s_stb_o and s_cyc_o low until m1 drops cyc; next arbitration proceeds normally.
- Reset asserted while in GNT1 with stb high → next edge gnt_o = 00, s_cyc_o = 0, pointer favours m0.

Source files
------------

// File: rtl/wb_sram_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of the SRAM controller.
// Grants are held for a whole cyc; a watchdog aborts accesses the slave never acknowledges.
module wb_sram_arbiter #(
   parameter int unsigned timeout   = 255,
   parameter int unsigned cnt_width = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        m0_cyc_i,
   input  logic        m0_stb_i,
   input  logic        m0_we_i,
   input  logic [31:0] m0_adr_i,
   input  logic [3:0]  m0_sel_i,
   input  logic [31:0] m0_dat_i,
   output logic [31:0] m0_dat_o,
   output logic        m0_ack_o,
   output logic        m0_err_o,
   input  logic        m1_cyc_i,
   input  logic        m1_stb_i,
   input  logic        m1_we_i,
   input  logic [31:0] m1_adr_i,
   input  logic [3:0]  m1_sel_i,
   input  logic [31:0] m1_dat_i,
   output logic [31:0] m1_dat_o,
   output logic        m1_ack_o,
   output logic        m1_err_o,
   output logic        s_cyc_o,
   output logic        s_stb_o,
   output logic        s_we_o,
   output logic [31:0] s_adr_o,
   output logic [3:0]  s_sel_o,
   output logic [31:0] s_dat_o,
   input  logic [31:0] s_dat_i,
   input  logic        s_ack_i,
   output logic [1:0]  gnt_o
);

   typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

   localparam bit                   WD_EN       = (timeout != 0);
   localparam logic [cnt_width-1:0] TIMEOUT_CNT = cnt_width'(timeout);

   state_t               state_reg, state_next;
   logic                 ptr_reg, ptr_next;     // 0 favours m0, 1 favours m1
   logic [cnt_width-1:0] cnt_reg, cnt_next;
   logic                 abort_reg, abort_next;
   logic                 timeout_hit;
   logic [1:0]           ack_vec, err_vec;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= IDLE;
         ptr_reg   <= 1'b0;
         cnt_reg   <= '0;
         abort_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         ptr_reg   <= ptr_next;
         cnt_reg   <= cnt_next;
         abort_reg <= abort_next;
      end
   end

   // An ack landing in the same cycle as the timeout takes precedence over the error.
   assign timeout_hit = WD_EN && s_stb_o && !s_ack_i && (cnt_reg == TIMEOUT_CNT);

   always_comb begin
      state_next = state_reg;
      ptr_next   = ptr_reg;
      case (state_reg)
         IDLE: begin
            if (m0_cyc_i && (!m1_cyc_i || !ptr_reg)) state_next = GNT0;
            else if (m1_cyc_i)                         state_next = GNT1;
         end
         GNT0: begin
            if (!m0_cyc_i) begin
               ptr_next   = 1'b1;
               state_next = m1_cyc_i ? GNT1 : IDLE;
            end
         end
         GNT1: begin
            if (!m1_cyc_i) begin
               ptr_next   = 1'b0;
               state_next = m0_cyc_i ? GNT0 : IDLE;
            end
         end
         default: state_next = IDLE;
      endcase

      cnt_next   = cnt_reg;
      abort_next = abort_reg;
      if (state_next != state_reg) begin
         cnt_next   = '0;
         abort_next = 1'b0;
      end else if (s_ack_i) begin
         cnt_next = '0;
      end else if (timeout_hit) begin
         cnt_next   = '0;
         abort_next = 1'b1;
      end else if (WD_EN && s_stb_o) begin
         cnt_next = cnt_reg + 1'b1;
      end
   end

   always_comb begin
      gnt_o   = 2'b00;
      s_cyc_o = 1'b0;
      s_stb_o = 1'b0;
      s_we_o  = 1'b0;
      s_adr_o = '0;
      s_sel_o = '0;
      s_dat_o = '0;
      case (state_reg)
         GNT0: begin
            gnt_o   = 2'b01;
            s_cyc_o = m0_cyc_i & ~abort_reg;
            s_stb_o = m0_stb_i & m0_cyc_i & ~abort_reg;
            s_we_o  = m0_we_i;
            s_adr_o = m0_adr_i;
            s_sel_o = m0_sel_i;
            s_dat_o = m0_dat_i;
         end
         GNT1: begin
            gnt_o   = 2'b10;
            s_cyc_o = m1_cyc_i & ~abort_reg;
            s_stb_o = m1_stb_i & m1_cyc_i & ~abort_reg;
            s_we_o  = m1_we_i;
            s_adr_o = m1_adr_i;
            s_sel_o = m1_sel_i;
            s_dat_o = m1_dat_i;
         end
         default: ;
      endcase
   end

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_resp
         assign ack_vec[gi] = gnt_o[gi] & ~abort_reg & s_ack_i;
         assign err_vec[gi] = gnt_o[gi] & timeout_hit;
      end
   endgenerate

   assign m0_ack_o = ack_vec[0];
   assign m1_ack_o = ack_vec[1];
   assign m0_err_o = err_vec[0];
   assign m1_err_o = err_vec[1];
   assign m0_dat_o = s_dat_i;
   assign m1_dat_o = s_dat_i;

endmodule

// File: tb/tb_wb_sram_arbiter.sv
// Randomized bench for wb_sram_arbiter, checked every cycle against a behavioural
// model tracking owner, favoured master, stall count and abort status.
module tb_wb_sram_arbiter;

   localparam int TIMEOUT = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        cyc [2];
   logic        stb [2];
   logic        we  [2];
   logic [31:0] adr [2];
   logic [3:0]  sel [2];
   logic [31:0] wdat[2];
   logic [31:0] s_dat_i;
   logic        s_ack_i;

   logic [31:0] m0_dat_o, m1_dat_o, s_adr_o, s_dat_o;
   logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
   logic        s_cyc_o, s_stb_o, s_we_o;
   logic [3:0]  s_sel_o;
   logic [1:0]  gnt_o;

   always #5 clk = ~clk;

   wb_sram_arbiter #(.timeout(TIMEOUT), .cnt_width(3)) dut (
      .clk(clk), .reset(reset),
      .m0_cyc_i(cyc[0]), .m0_stb_i(stb[0]), .m0_we_i(we[0]), .m0_adr_i(adr[0]),
      .m0_sel_i(sel[0]), .m0_dat_i(wdat[0]), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
      .m0_err_o(m0_err_o),
      .m1_cyc_i(cyc[1]), .m1_stb_i(stb[1]), .m1_we_i(we[1]), .m1_adr_i(adr[1]),
      .m1_sel_i(sel[1]), .m1_dat_i(wdat[1]), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
      .m1_err_o(m1_err_o),
      .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o),
      .s_sel_o(s_sel_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
      .gnt_o(gnt_o)
   );

   int n_vec = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
      end
   endtask

   // Model: owner 0 = nobody, 1 = m0, 2 = m1; favour is the master preferred on a tie.
   int   owner, favour, wd;
   bit   aborted;
   logic [1:0]  e_gnt, e_ack, e_err;
   logic        e_cyc, e_stb, e_we;
   logic [31:0] e_adr, e_dat;
   logic [3:0]  e_sel;
   int   ack_mode;

   initial begin
      reset   = 1'b1;
      s_dat_i = '0;
      s_ack_i = 1'b0;
      for (int k = 0; k < 2; k++) begin
         cyc[k] = 0; stb[k] = 0; we[k] = 0; adr[k] = '0; sel[k] = '0; wdat[k] = '0;
      end
      repeat (3) @(posedge clk);
      owner = 0; favour = 0; wd = 0; aborted = 0;
      ack_mode = 2;

      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         if (c % 60 == 0) ack_mode = $urandom_range(0, 3);
         reset = (c < 2) || ($urandom_range(0, 199) == 0);
         for (int k = 0; k < 2; k++) begin
            if (cyc[k]) begin
               if ($urandom_range(0, 7) == 0) cyc[k] = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
               cyc[k] = 1'b1;
            end
            stb[k]  = ($urandom_range(0, 3) != 0);
            we[k]   = 1'($urandom);
            adr[k]  = $urandom;
            sel[k]  = 4'($urandom);
            wdat[k] = $urandom;
         end
         s_dat_i = $urandom;
         s_ack_i = (ack_mode != 0) && ($urandom_range(0, 3) < ack_mode);
         #1;

         e_gnt = 2'b00; e_ack = 2'b00; e_err = 2'b00;
         e_cyc = 0; e_stb = 0; e_we = 0; e_adr = '0; e_sel = '0; e_dat = '0;
         if (owner != 0) begin
            int k;
            k = owner - 1;
            e_gnt[k] = 1'b1;
            e_cyc    = cyc[k] && !aborted;
            e_stb    = cyc[k] && stb[k] && !aborted;
            e_we     = we[k];
            e_adr    = adr[k];
            e_sel    = sel[k];
            e_dat    = wdat[k];
            e_ack[k] = s_ack_i && !aborted;
            e_err[k] = !aborted && (wd == TIMEOUT) && e_stb && !s_ack_i;
         end

         check("gnt", 80'(gnt_o), 80'(e_gnt));
         check("slave_bus", 80'({s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_sel_o, s_dat_o}),
               80'({e_cyc, e_stb, e_we, e_adr, e_sel, e_dat}));
         check("m0_ack_err", 80'({m0_ack_o, m0_err_o}), 80'({e_ack[0], e_err[0]}));
         check("m1_ack_err", 80'({m1_ack_o, m1_err_o}), 80'({e_ack[1], e_err[1]}));
         check("rdata", 80'({m0_dat_o, m1_dat_o}), 80'({s_dat_i, s_dat_i}));

         @(posedge clk);
         if (reset) begin
            owner = 0; favour = 0; wd = 0; aborted = 0;
         end else if (owner == 0) begin
            if (cyc[0] && (!cyc[1] || favour == 0)) owner = 1;
            else if (cyc[1])                         owner = 2;
            wd = 0;
         end else begin
            int k;
            k = owner - 1;
            if (!cyc[k]) begin
               favour  = 1 - k;
               owner   = cyc[1-k] ? (2 - k) : 0;
               wd      = 0;
               aborted = 0;
            end else if (e_err[k]) begin
               wd      = 0;
               aborted = 1;
            end else if (s_ack_i) begin
               wd = 0;
            end else if (e_stb) begin
               wd++;
            end
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
